// File: rtl/exc_stack_ctrl_pkg.sv
// Shared definitions for the exception entry/return sequencer:
//   state_t   - sequencer states
//   REG_*     - register-file indices used by the sequencer
//   slot_reg  - maps an exception-frame slot (0..7) to its register index
package exc_stack_ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ENTRY_SP,
    PUSH,
    ENTRY_WB,
    ENTRY_LR,
    VEC_FETCH,
    RET_SP,
    POP,
    RET_WB
  } state_t;

  localparam logic [3:0] REG_R12 = 4'd12;
  localparam logic [3:0] REG_SP  = 4'd13;
  localparam logic [3:0] REG_LR  = 4'd14;
  localparam logic [3:0] REG_PC  = 4'd15;

  localparam logic [2:0] SLOT_RET  = 3'd6;
  localparam logic [2:0] SLOT_XPSR = 3'd7;

  // Frame order: R0, R1, R2, R3, R12, LR, PC, xPSR.
  // The xPSR slot has no register-file home; it maps to 0 and is never written.
  function automatic logic [3:0] slot_reg(input logic [2:0] slot);
    case (slot)
      3'd4:    return REG_R12;
      3'd5:    return REG_LR;
      3'd6:    return REG_PC;
      3'd7:    return 4'd0;
      default: return {1'b0, slot};
    endcase
  endfunction

endpackage

// File: rtl/exc_stack_ctrl_if.sv
// Data-bus master/slave bundle used by the exception sequencer.
//   mem_req/mem_we/mem_addr/mem_wdata : driven by the master, held until mem_ready
//   mem_rdata/mem_ready               : driven by the slave
interface exc_stack_ctrl_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/exc_frame_addr.sv
// Exception-frame address arithmetic.
//   sp            : current SP as read from the register file
//   base          : latched frame base
//   idx           : frame slot index 0..7
//   stacked_align : bit 9 of the stacked xPSR seen on return
//   new_base      : frame base for entry, 8-byte aligned SP minus 32 (wraps)
//   align         : SP[2], records whether alignment padding was inserted
//   slot_addr     : base + 4*idx
//   ret_sp        : SP after return, undoing frame and optional padding
module exc_frame_addr (
  input  logic [31:0] sp,
  input  logic [31:0] base,
  input  logic [2:0]  idx,
  input  logic        stacked_align,
  output logic [31:0] new_base,
  output logic        align,
  output logic [31:0] slot_addr,
  output logic [31:0] ret_sp
);

  always_comb begin
    new_base  = (sp & ~32'h7) - 32'd32;
    align     = sp[2];
    slot_addr = base + {27'd0, idx, 2'b00};
    ret_sp    = base + 32'd32 + (stacked_align ? 32'd4 : 32'd0);
  end

endmodule

// File: rtl/exc_stack_ctrl.sv
// Exception entry/return sequencer for the Cortex-M0 core.
// Entry: read SP, push the 8-word frame, update SP/IPSR/EPSR, load LR with
// EXC_RETURN_VAL, fetch the vector into PC, pulse exc_ack.
// Return: read SP, pop the frame into R0-R3/R12/LR/PC and the PSR flags,
// restore SP, pulse ret_done.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   exc_req/exc_num/exc_ack        entry request / number / completion pulse
//   exc_ret/ret_done               return request pulse / completion pulse
//   ret_addr                       PC value to stack on entry
//   busy                           high whenever not IDLE
//   r_psr_in, r_primask_in         special-bank read data
//   w_*_en, w_*_in                 special-bank write enables / data
//   rf_rd_addr/rf_rd_data          register-file read (combinational)
//   rf_wr_en/rf_wr_addr/rf_wr_data register-file write
//   mem                            data-bus master
module exc_stack_ctrl
  import exc_stack_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_RETURN_VAL = 32'hFFFF_FFF9,
  parameter logic [31:0] VTOR_BASE      = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exc_req,
  input  logic [5:0]  exc_num,
  input  logic        exc_ret,
  input  logic [31:0] ret_addr,
  output logic        exc_ack,
  output logic        ret_done,
  output logic        busy,
  input  logic [31:0] r_psr_in,
  input  logic [31:0] r_primask_in,
  output logic        w_N_en,
  output logic        w_Z_en,
  output logic        w_C_en,
  output logic        w_V_en,
  output logic        w_epsr_en,
  output logic        w_ipsr_en,
  output logic        w_N_in,
  output logic        w_Z_in,
  output logic        w_C_in,
  output logic        w_V_in,
  output logic        w_epsr_in,
  output logic [5:0]  w_ipsr_in,
  output logic [3:0]  rf_rd_addr,
  input  logic [31:0] rf_rd_data,
  output logic        rf_wr_en,
  output logic [3:0]  rf_wr_addr,
  output logic [31:0] rf_wr_data,
  exc_stack_ctrl_if.master mem
);

  state_t      state;
  state_t      state_nx;
  logic [2:0]  idx;
  logic [31:0] base;
  logic        align;
  logic [5:0]  num;
  logic        ret_align;

  logic [31:0] new_base;
  logic        sp_align;
  logic [31:0] slot_addr;
  logic [31:0] ret_sp;
  logic        primask_set;
  logic        unmaskable;
  logic        accept;
  logic        last_slot;

  exc_frame_addr u_frame_addr (
    .sp            (rf_rd_data),
    .base          (base),
    .idx           (idx),
    .stacked_align (ret_align),
    .new_base      (new_base),
    .align         (sp_align),
    .slot_addr     (slot_addr),
    .ret_sp        (ret_sp)
  );

  always_comb begin
    primask_set = |(r_primask_in & 32'h1);
    unmaskable  = (exc_num == 6'd2) || (exc_num == 6'd3);
    accept      = exc_req && (!primask_set || unmaskable);
    last_slot   = (idx == SLOT_XPSR);
  end

  // State register and datapath latches
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      base      <= '0;
      align     <= 1'b0;
      num       <= '0;
      ret_align <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          idx <= '0;
          if (!exc_ret && accept) num <= exc_num;
        end
        ENTRY_SP: begin
          base  <= new_base;
          align <= sp_align;
        end
        PUSH: begin
          if (mem.mem_ready) idx <= idx + 3'd1;
        end
        RET_SP: begin
          base <= rf_rd_data;
        end
        POP: begin
          if (mem.mem_ready) begin
            idx <= idx + 3'd1;
            if (last_slot) ret_align <= mem.mem_rdata[9];
          end
        end
        default: ;
      endcase
    end
  end

  // Next-state logic; a return request takes priority over a pending entry
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (exc_ret)     state_nx = RET_SP;
        else if (accept) state_nx = ENTRY_SP;
      end
      ENTRY_SP:  state_nx = PUSH;
      PUSH:      if (mem.mem_ready && last_slot) state_nx = ENTRY_WB;
      ENTRY_WB:  state_nx = ENTRY_LR;
      ENTRY_LR:  state_nx = VEC_FETCH;
      VEC_FETCH: if (mem.mem_ready) state_nx = IDLE;
      RET_SP:    state_nx = POP;
      POP:       if (mem.mem_ready && last_slot) state_nx = RET_WB;
      RET_WB:    state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  // Outputs; forced to zero while rst is high so an aborted sequence
  // performs no bus or register writes in its final cycle
  always_comb begin
    exc_ack       = 1'b0;
    ret_done      = 1'b0;
    busy          = 1'b0;
    w_N_en        = 1'b0;
    w_Z_en        = 1'b0;
    w_C_en        = 1'b0;
    w_V_en        = 1'b0;
    w_epsr_en     = 1'b0;
    w_ipsr_en     = 1'b0;
    w_N_in        = 1'b0;
    w_Z_in        = 1'b0;
    w_C_in        = 1'b0;
    w_V_in        = 1'b0;
    w_epsr_in     = 1'b0;
    w_ipsr_in     = '0;
    rf_rd_addr    = '0;
    rf_wr_en      = 1'b0;
    rf_wr_addr    = '0;
    rf_wr_data    = '0;
    mem.mem_req   = 1'b0;
    mem.mem_we    = 1'b0;
    mem.mem_addr  = '0;
    mem.mem_wdata = '0;
    if (!rst) begin
      busy = (state != IDLE);
      case (state)
        ENTRY_SP: rf_rd_addr = REG_SP;
        PUSH: begin
          rf_rd_addr    = slot_reg(idx);
          mem.mem_req   = 1'b1;
          mem.mem_we    = 1'b1;
          mem.mem_addr  = slot_addr;
          if (idx == SLOT_RET)
            mem.mem_wdata = ret_addr;
          else if (last_slot)
            mem.mem_wdata = {r_psr_in[31:10], align, r_psr_in[8:0]};
          else
            mem.mem_wdata = rf_rd_data;
        end
        ENTRY_WB: begin
          rf_wr_en   = 1'b1;
          rf_wr_addr = REG_SP;
          rf_wr_data = base;
          w_ipsr_en  = 1'b1;
          w_ipsr_in  = num;
          w_epsr_en  = 1'b1;
          w_epsr_in  = 1'b1;
        end
        ENTRY_LR: begin
          rf_wr_en   = 1'b1;
          rf_wr_addr = REG_LR;
          rf_wr_data = EXC_RETURN_VAL;
        end
        VEC_FETCH: begin
          mem.mem_req  = 1'b1;
          mem.mem_addr = VTOR_BASE + {24'd0, num, 2'b00};
          if (mem.mem_ready) begin
            rf_wr_en   = 1'b1;
            rf_wr_addr = REG_PC;
            rf_wr_data = mem.mem_rdata & ~32'h1;
            exc_ack    = 1'b1;
          end
        end
        RET_SP: rf_rd_addr = REG_SP;
        POP: begin
          mem.mem_req  = 1'b1;
          mem.mem_addr = slot_addr;
          if (mem.mem_ready) begin
            if (last_slot) begin
              w_N_en    = 1'b1;
              w_Z_en    = 1'b1;
              w_C_en    = 1'b1;
              w_V_en    = 1'b1;
              w_epsr_en = 1'b1;
              w_ipsr_en = 1'b1;
              w_N_in    = mem.mem_rdata[31];
              w_Z_in    = mem.mem_rdata[30];
              w_C_in    = mem.mem_rdata[29];
              w_V_in    = mem.mem_rdata[28];
              w_epsr_in = mem.mem_rdata[24];
              w_ipsr_in = mem.mem_rdata[5:0];
            end else begin
              rf_wr_en   = 1'b1;
              rf_wr_addr = slot_reg(idx);
              rf_wr_data = mem.mem_rdata;
            end
          end
        end
        RET_WB: begin
          rf_wr_en   = 1'b1;
          rf_wr_addr = REG_SP;
          rf_wr_data = ret_sp;
          ret_done   = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_exc_stack_ctrl.sv
// Directed bench for exc_stack_ctrl with a behavioural memory, register file
// and special register bank.
module tb_exc_stack_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        exc_req;
  logic [5:0]  exc_num;
  logic        exc_ret;
  logic [31:0] ret_addr;
  logic        exc_ack;
  logic        ret_done;
  logic        busy;
  logic [31:0] psr;
  logic [31:0] primask;
  logic        w_N_en, w_Z_en, w_C_en, w_V_en, w_epsr_en, w_ipsr_en;
  logic        w_N_in, w_Z_in, w_C_in, w_V_in, w_epsr_in;
  logic [5:0]  w_ipsr_in;
  logic [3:0]  rf_rd_addr;
  logic [31:0] rf_rd_data;
  logic        rf_wr_en;
  logic [3:0]  rf_wr_addr;
  logic [31:0] rf_wr_data;

  exc_stack_ctrl_if mem_if ();

  exc_stack_ctrl #(
    .EXC_RETURN_VAL (32'hFFFF_FFF9),
    .VTOR_BASE      (32'h0000_0000)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .exc_req      (exc_req),
    .exc_num      (exc_num),
    .exc_ret      (exc_ret),
    .ret_addr     (ret_addr),
    .exc_ack      (exc_ack),
    .ret_done     (ret_done),
    .busy         (busy),
    .r_psr_in     (psr),
    .r_primask_in (primask),
    .w_N_en       (w_N_en),
    .w_Z_en       (w_Z_en),
    .w_C_en       (w_C_en),
    .w_V_en       (w_V_en),
    .w_epsr_en    (w_epsr_en),
    .w_ipsr_en    (w_ipsr_en),
    .w_N_in       (w_N_in),
    .w_Z_in       (w_Z_in),
    .w_C_in       (w_C_in),
    .w_V_in       (w_V_in),
    .w_epsr_in    (w_epsr_in),
    .w_ipsr_in    (w_ipsr_in),
    .rf_rd_addr   (rf_rd_addr),
    .rf_rd_data   (rf_rd_data),
    .rf_wr_en     (rf_wr_en),
    .rf_wr_addr   (rf_wr_addr),
    .rf_wr_data   (rf_wr_data),
    .mem          (mem_if)
  );

  always #5 clk = ~clk;

  bit [31:0]   mem_arr [256];
  bit [31:0]   rf [16];
  logic [31:0] wlog [$];
  int          wait_states = 0;
  int          wcnt = 0;
  int          stab_err = 0;
  int          stall_cnt = 0;
  logic        pend = 1'b0;
  logic        p_we;
  logic [31:0] p_addr, p_wdata;

  // Backdoor pokes, applied by the storage process at the next posedge
  logic        bd_v = 1'b0;
  int          bd_sel = 0;
  int          bd_idx = 0;
  logic [31:0] bd_data = '0;

  always_comb begin
    mem_if.mem_ready = mem_if.mem_req && (wcnt == wait_states);
    mem_if.mem_rdata = mem_arr[mem_if.mem_addr[9:2]];
    rf_rd_data       = rf[rf_rd_addr];
  end

  always @(posedge clk) begin
    if (mem_if.mem_req && !mem_if.mem_ready) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  always @(posedge clk) begin
    if (pend && (!mem_if.mem_req || mem_if.mem_we !== p_we ||
                 mem_if.mem_addr !== p_addr || mem_if.mem_wdata !== p_wdata))
      stab_err = stab_err + 1;
    if (mem_if.mem_req && !mem_if.mem_ready) stall_cnt = stall_cnt + 1;
    pend    = mem_if.mem_req && !mem_if.mem_ready;
    p_we    = mem_if.mem_we;
    p_addr  = mem_if.mem_addr;
    p_wdata = mem_if.mem_wdata;
    if (mem_if.mem_req && mem_if.mem_we && mem_if.mem_ready) begin
      mem_arr[mem_if.mem_addr[9:2]] = mem_if.mem_wdata;
      wlog.push_back(mem_if.mem_addr);
    end
    if (rf_wr_en) rf[rf_wr_addr] = rf_wr_data;
    if (w_N_en)    psr[31]  = w_N_in;
    if (w_Z_en)    psr[30]  = w_Z_in;
    if (w_C_en)    psr[29]  = w_C_in;
    if (w_V_en)    psr[28]  = w_V_in;
    if (w_epsr_en) psr[24]  = w_epsr_in;
    if (w_ipsr_en) psr[5:0] = w_ipsr_in;
    if (bd_v) begin
      case (bd_sel)
        0:       rf[bd_idx] = bd_data;
        1:       mem_arr[bd_idx] = bd_data;
        default: psr = bd_data;
      endcase
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic poke(input int sel, input int i, input logic [31:0] d);
    bd_sel  = sel;
    bd_idx  = i;
    bd_data = d;
    bd_v    = 1'b1;
    @(negedge clk);
    bd_v    = 1'b0;
  endtask

  // which: 0 = exc_ack, 1 = ret_done; cycles = -1 on timeout
  task automatic wait_for(input int which, input int budget, output int cycles);
    cycles = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      exc_ret = 1'b0;
      cycles++;
      if ((which == 0 && exc_ack) || (which == 1 && ret_done)) return;
    end
    cycles = -1;
  endtask

  int          cyc;
  int          w0, s0, st0, nreq;
  logic [31:0] sp0, psr0;
  logic [31:0] frame_exp [8];

  initial begin
    rst      = 1'b1;
    exc_req  = 1'b0;
    exc_num  = '0;
    exc_ret  = 1'b0;
    ret_addr = 32'h0000_1234;
    primask  = '0;
    @(negedge clk);
    for (int i = 0; i < 16; i++) poke(0, i, 32'h1111_0000 + i);
    poke(0, 13, 32'h2000_0100);
    poke(2, 0, 32'h6100_0000);
    poke(1, 11, 32'h0000_0401);
    poke(1, 5,  32'h0000_0301);
    poke(1, 7,  32'h0000_0501);
    poke(1, 2,  32'h0000_0201);

    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_mem_req", {31'd0, mem_if.mem_req}, 32'd0);
    chk("rst_rf_wr_en", {31'd0, rf_wr_en}, 32'd0);
    chk("rst_exc_ack", {31'd0, exc_ack}, 32'd0);
    chk("rst_rf_rd_addr", {28'd0, rf_rd_addr}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // Entry, aligned SP
    w0 = wlog.size();
    exc_num = 6'd11;
    exc_req = 1'b1;
    wait_for(0, 100, cyc);
    exc_req = 1'b0;
    chk("t1_latency", cyc, 32'd12);
    chk("t1_pc_addr", {28'd0, rf_wr_addr}, 32'd15);
    chk("t1_pc_data", rf_wr_data, 32'h0000_0400);
    chk("t1_nwrites", wlog.size() - w0, 32'd8);
    for (int i = 0; i < 8; i++)
      chk("t1_waddr", wlog[w0 + i], 32'h2000_00E0 + 32'(4 * i));
    frame_exp = '{32'h1111_0000, 32'h1111_0001, 32'h1111_0002, 32'h1111_0003,
                  32'h1111_000C, 32'h1111_000E, 32'h0000_1234, 32'h6100_0000};
    for (int i = 0; i < 8; i++) chk("t1_frame", mem_arr[56 + i], frame_exp[i]);
    @(negedge clk);
    chk("t1_ack_pulse", {31'd0, exc_ack}, 32'd0);
    chk("t1_busy", {31'd0, busy}, 32'd0);
    chk("t1_sp", rf[13], 32'h2000_00E0);
    chk("t1_lr", rf[14], 32'hFFFF_FFF9);
    chk("t1_pc", rf[15], 32'h0000_0400);
    chk("t1_psr", psr, 32'h6100_000B);

    // Return with xPSR=0xA100_0000; a simultaneous entry request stays pending
    poke(1, 63, 32'hA100_0000);
    for (int i = 0; i < 4; i++) poke(0, i, 32'hDEAD_0000);
    poke(0, 12, 32'hDEAD_0000);
    poke(0, 14, 32'hDEAD_0000);
    poke(0, 15, 32'hDEAD_0000);
    exc_ret = 1'b1;
    exc_req = 1'b1;
    exc_num = 6'd5;
    wait_for(1, 100, cyc);
    chk("t2_latency", cyc, 32'd10);
    chk("t2_sp_wr", rf_wr_data, 32'h2000_0100);
    chk("t2_psr", psr, 32'hA100_0000);
    for (int i = 0; i < 4; i++) chk("t2_rlo", rf[i], frame_exp[i]);
    chk("t2_r12", rf[12], 32'h1111_000C);
    chk("t2_lr", rf[14], 32'h1111_000E);
    chk("t2_pc", rf[15], 32'h0000_1234);
    wait_for(0, 100, cyc);
    exc_req = 1'b0;
    chk("t2_pending_latency", cyc, 32'd13);
    @(negedge clk);
    chk("t2_pending_psr", psr, 32'hA100_0005);
    chk("t2_pending_pc", rf[15], 32'h0000_0300);

    // Entry, unaligned SP, then return restores it
    poke(0, 13, 32'h2000_0104);
    w0 = wlog.size();
    exc_num = 6'd7;
    exc_req = 1'b1;
    wait_for(0, 100, cyc);
    exc_req = 1'b0;
    chk("t3_latency", cyc, 32'd12);
    chk("t3_base", wlog[w0], 32'h2000_00E0);
    chk("t3_xpsr", mem_arr[63], 32'hA100_0205);
    @(negedge clk);
    chk("t3_sp", rf[13], 32'h2000_00E0);
    exc_ret = 1'b1;
    wait_for(1, 100, cyc);
    chk("t3_ret_latency", cyc, 32'd10);
    @(negedge clk);
    chk("t3_ret_sp", rf[13], 32'h2000_0104);
    chk("t3_ret_busy", {31'd0, busy}, 32'd0);
    chk("t3_ret_done_pulse", {31'd0, ret_done}, 32'd0);

    // Masked request stays pending; NMI is taken despite PRIMASK
    primask = 32'd1;
    exc_num = 6'd15;
    exc_req = 1'b1;
    nreq = 0;
    repeat (20) begin
      @(negedge clk);
      if (mem_if.mem_req || busy) nreq++;
    end
    chk("t4_masked", nreq, 32'd0);
    exc_num = 6'd2;
    wait_for(0, 100, cyc);
    exc_req = 1'b0;
    chk("t4_nmi_latency", cyc, 32'd12);
    @(negedge clk);
    primask = '0;
    chk("t4_pc", rf[15], 32'h0000_0200);
    chk("t4_ipsr", {26'd0, psr[5:0]}, 32'd2);

    // Three wait states per transfer
    wait_states = 3;
    s0  = stab_err;
    st0 = stall_cnt;
    w0  = wlog.size();
    exc_num = 6'd11;
    exc_req = 1'b1;
    wait_for(0, 200, cyc);
    exc_req = 1'b0;
    chk("t5_latency", cyc, 32'd39);
    chk("t5_stable", stab_err - s0, 32'd0);
    chk("t5_stalls", stall_cnt - st0, 32'd27);
    chk("t5_nwrites", wlog.size() - w0, 32'd8);
    chk("t5_base", wlog[w0], 32'h2000_00C0);
    @(negedge clk);
    wait_states = 0;
    chk("t5_sp", rf[13], 32'h2000_00C0);

    // Reset while pushing slot 4
    w0   = wlog.size();
    sp0  = rf[13];
    psr0 = psr;
    exc_num = 6'd11;
    exc_req = 1'b1;
    repeat (6) @(negedge clk);
    chk("t6_slot4_addr", mem_if.mem_addr, 32'h2000_00B0);
    chk("t6_pre_writes", wlog.size() - w0, 32'd4);
    rst = 1'b1;
    exc_req = 1'b0;
    @(negedge clk);
    chk("t6_busy", {31'd0, busy}, 32'd0);
    chk("t6_mem_req", {31'd0, mem_if.mem_req}, 32'd0);
    chk("t6_mem_addr", mem_if.mem_addr, 32'd0);
    chk("t6_rf_wr_en", {31'd0, rf_wr_en}, 32'd0);
    chk("t6_ipsr_en", {31'd0, w_ipsr_en}, 32'd0);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    chk("t6_writes", wlog.size() - w0, 32'd4);
    chk("t6_sp", rf[13], sp0);
    chk("t6_psr", psr, psr0);
    chk("t6_idle", {31'd0, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/exc_stack_ctrl.md
Name: exc_stack_ctrl

Overview:
- Exception entry/return sequencer for the Cortex-M0 core.
- Acts as the writer and reader of the special register bank. Reads current PSR/PRIMASK, stacks the 8-word ARMv6-M frame to memory on entry, and writes IPSR/flags back on return.
- Sits between the core control unit, the general register file, the data-bus master and the special register bank.

Parameters:
- EXC_RETURN_VAL, 32'hFFFF_FFF9, value loaded into LR on entry (thread, MSP).
- VTOR_BASE, 32'h0000_0000, vector table base address.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- exc_req  in  1  exception request, level, held until exc_ack
- exc_num  in  6  exception number, valid with exc_req
- exc_ret  in  1  one-cycle pulse; core executed BX/POP with EXC_RETURN
- ret_addr  in  32  return address to stack as PC
- exc_ack  out  1  one-cycle pulse when entry completes
- ret_done  out  1  one-cycle pulse when return completes
- busy  out  1  high in every non-IDLE state; core stalls
- r_psr_in  in  32  current xPSR from special bank
- r_primask_in  in  32  current PRIMASK
- w_N_en/w_Z_en/w_C_en/w_V_en/w_epsr_en/w_ipsr_en  out  1 each  special-bank write enables
- w_N_in/w_Z_in/w_C_in/w_V_in/w_epsr_in  out  1 each  flag write data
- w_ipsr_in  out  6  IPSR write data
- rf_rd_addr  out  4  register-file read address (combinational rf_rd_data)
- rf_rd_data  in  32  register-file read data
- rf_wr_en  out  1  register-file write strobe
- rf_wr_addr  out  4  register-file write address
- rf_wr_data  out  32  register-file write data
- mem_req  out  1  bus request
- mem_we  out  1  1 = write
- mem_addr  out  32  word address (bits[1:0]=0)
- mem_wdata  out  32  write data
- mem_rdata  in  32  read data, valid with mem_ready
- mem_ready  in  1  transfer complete

Behaviour:
- Reset: state IDLE. All outputs 0. Index counter 0, frame base 0. A reset in any state aborts the sequence at the next edge with no further bus or register writes.
- Acceptance in IDLE:
  - exc_req accepted if r_primask_in[0]==0, or exc_num==2 (NMI), or exc_num==3 (HardFault).
  - Masked requests stay pending.
  - exc_ret ignored unless IDLE.
  - exc_req and exc_ret in the same cycle: exc_ret wins, exc_req stays pending.
- ENTRY_SP (1 cycle): rf_rd_addr=13. Latch align=SP[2]. Latch base=(SP & ~32'h7) - 32 (32-bit wrap).
- PUSH (8 transfers, idx 0..7): address base+4*idx. Data in order R0, R1, R2, R3, R12, LR, ret_addr, xPSR.
  - Stacked xPSR = r_psr_in with bit9 forced to align.
  - mem_req/mem_we/mem_addr/mem_wdata held stable until mem_ready. idx increments on mem_ready.
  - rf_rd_addr driven combinationally from idx.
- ENTRY_WB (1 cycle):
  - rf_wr SP=base.
  - w_ipsr_en=1, w_ipsr_in=exc_num.
  - w_epsr_en=1, w_epsr_in=1.
- ENTRY_LR (1 cycle): rf_wr LR=EXC_RETURN_VAL.
- VEC_FETCH: read VTOR_BASE + 4*exc_num. On mem_ready: rf_wr PC (addr 15) = mem_rdata & ~1, pulse exc_ack, go to IDLE.
- Entry latency with zero-wait memory: 12 cycles from acceptance to exc_ack.
- RET_SP (1 cycle): base=SP.
- POP (8 reads, base+4*idx):
  - On each mem_ready, write the register file: R0..R3, R12, LR, PC.
  - The word at idx 7 (stacked xPSR) is not written to the register file. It drives w_N/Z/C/V/epsr/ipsr enables, all 1 that cycle, with data from bits 31/30/29/28/24/5:0.
- RET_WB (1 cycle): rf_wr SP = base + 32 + (stacked xPSR[9] ? 4 : 0). Pulse ret_done, go to IDLE.
- Never two rf_wr in one cycle. mem_req never asserted in IDLE.

Decomposition:
- Shared package: state enum (IDLE, ENTRY_SP, PUSH, ENTRY_WB, ENTRY_LR, VEC_FETCH, RET_SP, POP, RET_WB), register index constants (SP=13, LR=14, PC=15), and the frame-slot to register mapping function.
- One natural sub-module, exc_frame_addr: computes base, slot address and adjusted SP.

Test Plan:
- Entry, aligned SP: SP=0x2000_0100, exc_num=11, zero-wait memory.
  - Writes go to 0x2000_00E0..0x2000_00FC in order, with xPSR bit9=0.
  - Then SP=0x2000_00E0, IPSR=11, LR=0xFFFF_FFF9, and PC taken from the vector at 0x2C.
  - exc_ack lands 12 cycles after acceptance.
- Entry, unaligned SP: SP=0x2000_0104.
  - base=0x2000_00E0 and stacked xPSR bit9=1.
  - A following return restores SP=0x2000_0104.
- Masking: PRIMASK=1 with exc_num=15 -> no mem_req for 20 cycles.
  - Switching exc_num to 2 -> entry proceeds.
- Return: frame holding xPSR=0xA100_0000.
  - Flags N=1, Z=0, C=1, V=0, T=1, IPSR=0.
  - R0..PC restored, ret_done pulses, busy drops.
- Wait states: mem_ready delayed 3 cycles per transfer -> bus outputs held stable throughout, entry takes 12+27 cycles.
- Reset mid-PUSH (idx=4) -> next cycle IDLE, all outputs 0, no SP/IPSR write.
